// File: rtl/ising_run_ctrl_pkg.sv
// rtl/ising_run_ctrl_pkg.sv - shared state encoding, timing defaults and command record for the run controller
package ising_run_ctrl_pkg;

  // Width of every data/address/setting bus around the controller
  localparam int DATA_W = 32;

  // Default geometry and sequencing timing
  localparam int DEF_N            = 3;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int DEF_ARM_CYCLES   = 2;

  // Controller states, binary encoded
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUN     = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RD_OUT  = 3'd6,
    ST_FIN     = 3'd7
  } state_t;

  // Command fields captured on a command transfer
  typedef struct packed {
    logic [DATA_W-1:0] run_len;
    logic [DATA_W-1:0] counter_max;
    logic [DATA_W-1:0] counter_cutoff;
  } run_cmd_t;

  // Down-counter preload for the RUN phase; a zero length still runs one cycle
  function automatic logic [DATA_W-1:0] run_load(input logic [DATA_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

endpackage

// File: rtl/ising_run_ctrl_if.sv
// rtl/ising_run_ctrl_if.sv - command and result handshake bundle between host and run controller
interface ising_run_ctrl_if;
  import ising_run_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_run_len;
  logic [DATA_W-1:0] cmd_counter_max;
  logic [DATA_W-1:0] cmd_counter_cutoff;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  // Controller side: accepts commands, produces results
  modport master (
    input  cmd_valid, cmd_run_len, cmd_counter_max, cmd_counter_cutoff, res_ready,
    output cmd_ready, res_valid, res_data, res_last
  );

  // Host side: issues commands, consumes results
  modport slave (
    output cmd_valid, cmd_run_len, cmd_counter_max, cmd_counter_cutoff, res_ready,
    input  cmd_ready, res_valid, res_data, res_last
  );

endinterface

// File: rtl/ising_run_ctrl.sv
// rtl/ising_run_ctrl.sv - run sequencer for the Ising oscillator core and phase sampler
module ising_run_ctrl
  import ising_run_ctrl_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int ARM_CYCLES   = DEF_ARM_CYCLES
) (
  input  logic              clk,
  input  logic              rstn,
  ising_run_ctrl_if.master  bus,
  input  logic              abort,
  output logic              ising_rstn,
  output logic              start,
  output logic [DATA_W-1:0] counter_max,
  output logic [DATA_W-1:0] counter_cutoff,
  output logic [DATA_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] phase,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] RESET_LOAD = DATA_W'(RESET_CYCLES - 1);
  localparam logic [DATA_W-1:0] ARM_LOAD   = DATA_W'(ARM_CYCLES - 1);
  localparam logic [DATA_W-1:0] LAST_IDX   = DATA_W'(N - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_cnt;
  run_cmd_t          r_cmd;
  logic              r_ising_rstn;
  logic              r_start;
  logic [DATA_W-1:0] r_rd_addr;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_last;
  logic              r_done;

  logic              w_cmd_ready;
  logic              w_xfer;
  logic              w_cnt_zero;
  logic              w_last_idx;

  // An abort in the same cycle blocks acceptance, so abort always wins over a command
  assign w_cmd_ready = (r_state == ST_IDLE) && !abort;
  assign w_xfer      = bus.cmd_valid && w_cmd_ready;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last_idx  = (r_rd_addr == LAST_IDX);

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_last   = r_res_last;
  assign ising_rstn     = r_ising_rstn;
  assign start          = r_start;
  assign rd_addr        = r_rd_addr;
  assign counter_max    = r_cmd.counter_max;
  assign counter_cutoff = r_cmd.counter_cutoff;
  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;

  // Sequencer: one shared down-counter times RESET, ARM and RUN; the spin index doubles as rd_addr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cmd        <= '0;
      r_ising_rstn <= 1'b0;
      r_start      <= 1'b0;
      r_rd_addr    <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_last   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && abort) begin
        // Abort drops everything in flight and leaves the core held in reset
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_ising_rstn <= 1'b0;
        r_start      <= 1'b0;
        r_res_valid  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_xfer) begin
              r_cmd.run_len        <= bus.cmd_run_len;
              r_cmd.counter_max    <= bus.cmd_counter_max;
              r_cmd.counter_cutoff <= bus.cmd_counter_cutoff;
              r_cnt                <= RESET_LOAD;
              r_ising_rstn         <= 1'b0;
              r_start              <= 1'b0;
              r_state              <= ST_RESET;
            end
          end
          ST_RESET: begin
            if (w_cnt_zero) begin
              r_cnt        <= ARM_LOAD;
              r_ising_rstn <= 1'b1;
              r_state      <= ST_ARM;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_ARM: begin
            if (w_cnt_zero) begin
              r_cnt   <= run_load(r_cmd.run_len);
              r_start <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_RUN: begin
            if (w_cnt_zero) begin
              r_rd_addr <= '0;
              r_state   <= ST_RD_ADDR;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_RD_ADDR: begin
            r_state <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            // Sampler output for rd_addr is valid in this cycle
            r_res_data  <= phase;
            r_res_last  <= w_last_idx;
            r_res_valid <= 1'b1;
            r_state     <= ST_RD_OUT;
          end
          ST_RD_OUT: begin
            if (bus.res_ready) begin
              r_res_valid <= 1'b0;
              if (w_last_idx) begin
                r_start <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_FIN;
              end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_state   <= ST_RD_ADDR;
              end
            end
          end
          ST_FIN: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
